// File: rtl/cplx_fixed_pkg.sv
// Shared fixed-point format helpers for the complex datapath (multiplier and accumulator).
// Holds default QI.QF constants, width helpers, the accumulator state enum and the saturation function.
package cplx_fixed_pkg;

    localparam int QI_DEFAULT      = 4;
    localparam int QF_DEFAULT      = 4;
    localparam int N_TERMS_DEFAULT = 4;
    localparam int GUARD_DEFAULT   = 2;
    localparam int SAT_CALC_W      = 64;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } cacc_state_e;

    typedef struct packed {
        logic [SAT_CALC_W-1:0] value;
        logic                  saturated;
    } sat_result_t;

    function automatic int width_of(input int qi, input int qf);
        return qi + qf;
    endfunction

    function automatic int accw_of(input int qi, input int qf, input int guard);
        return qi + qf + guard;
    endfunction

    // Clamps a sign-extended value into a w-bit two's-complement range; exact bounds are not saturation.
    function automatic sat_result_t sat_to_width(input logic signed [SAT_CALC_W-1:0] v, input int w);
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        sat_result_t                  res;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) begin
            res.value     = max_v;
            res.saturated = 1'b1;
        end else if (v < min_v) begin
            res.value     = min_v;
            res.saturated = 1'b1;
        end else begin
            res.value     = v;
            res.saturated = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Narrows a signed IN_W-bit value to OUT_W bits with clamping, flagging when the clamp engaged.
module fixed_saturate
    import cplx_fixed_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             saturated
);

    generate
        if (IN_W <= OUT_W || IN_W > SAT_CALC_W) begin : g_bad_width
            $error("fixed_saturate: IN_W must exceed OUT_W and fit in SAT_CALC_W");
        end
    endgenerate

    logic signed [SAT_CALC_W-1:0] din_ext;
    sat_result_t                  res;
    logic                         unused_hi;

    assign din_ext   = {{(SAT_CALC_W-IN_W){din[IN_W-1]}}, din};
    assign res       = sat_to_width(din_ext, OUT_W);
    assign dout      = res.value[OUT_W-1:0];
    assign saturated = res.saturated;
    // Upper bits are just the sign extension of the clamped result.
    assign unused_hi = ^res.value[SAT_CALC_W-1:OUT_W];

endmodule

// File: rtl/complex_accumulator.sv
// Accumulates N_TERMS complex QI.QF products and emits one saturated sum per frame over valid/ready.
// Optional CACC_SKID_EN: keep accumulating the next frame while a result waits in the output register.
module complex_accumulator
    import cplx_fixed_pkg::*;
#(
    parameter int QI      = QI_DEFAULT,
    parameter int QF      = QF_DEFAULT,
    parameter int N_TERMS = N_TERMS_DEFAULT,
    parameter int GUARD   = GUARD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QI+QF-1:0]     in_Re,
    input  logic [QI+QF-1:0]     in_Im,
    input  logic                 in_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QI+QF-1:0]     out_Re,
    output logic [QI+QF-1:0]     out_Im,
    output logic                 out_ovf
);

    localparam int WIDTH = width_of(QI, QF);
    localparam int ACCW  = accw_of(QI, QF, GUARD);
    localparam int CNTW  = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(N_TERMS - 1);

    generate
        if (N_TERMS < 2) begin : g_bad_terms
            $error("complex_accumulator: N_TERMS must be >= 2");
        end
        if (GUARD < $clog2(N_TERMS)) begin : g_bad_guard
            $error("complex_accumulator: GUARD must be >= clog2(N_TERMS)");
        end
    endgenerate

    cacc_state_e      state_reg;
    cacc_state_e      state_next;
    logic [CNTW-1:0]  cnt_reg;
    logic             sticky_reg;
    logic             out_ovf_reg;

    logic             accept;
    logic             last_beat;
    logic             frame_done;

    logic [WIDTH-1:0] lane_in  [2];
    logic [WIDTH-1:0] lane_out [2];
    logic             lane_sat [2];

    assign lane_in[0] = in_Re;
    assign lane_in[1] = in_Im;

    assign last_beat  = (cnt_reg == LAST_CNT);
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && last_beat;

`ifdef CACC_SKID_EN
    // Only the completing beat must wait, and only while the previous result is still unclaimed.
    assign in_ready = !(last_beat && (state_reg == OUT) && !out_ready);
`else
    assign in_ready = (state_reg == ACC);
`endif

    assign out_valid = (state_reg == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACC: begin
                if (frame_done) begin
                    state_next = OUT;
                end
            end
            OUT: begin
`ifdef CACC_SKID_EN
                // A fresh result loading on the same edge as the handshake keeps the output valid.
                if (out_ready && !frame_done) begin
                    state_next = ACC;
                end
`else
                if (out_ready) begin
                    state_next = ACC;
                end
`endif
            end
            default: state_next = ACC;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [ACCW-1:0]  acc_reg;
            logic [ACCW-1:0]  sum;
            logic [WIDTH-1:0] sat_val;
            logic [WIDTH-1:0] out_reg;
            logic             sat_flag;

            // GUARD bits absorb N_TERMS worth of growth, so this add never wraps.
            assign sum = acc_reg + {{GUARD{lane_in[gi][WIDTH-1]}}, lane_in[gi]};

            fixed_saturate #(
                .IN_W  (ACCW),
                .OUT_W (WIDTH)
            ) u_sat (
                .din       (sum),
                .dout      (sat_val),
                .saturated (sat_flag)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                    out_reg <= '0;
                end else if (accept) begin
                    if (last_beat) begin
                        acc_reg <= '0;
                        out_reg <= sat_val;
                    end else begin
                        acc_reg <= sum;
                    end
                end
            end

            assign lane_out[gi] = out_reg;
            assign lane_sat[gi] = sat_flag;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            sticky_reg  <= 1'b0;
            out_ovf_reg <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                cnt_reg     <= '0;
                sticky_reg  <= 1'b0;
                out_ovf_reg <= sticky_reg | in_ovf | lane_sat[0] | lane_sat[1];
            end else begin
                cnt_reg    <= cnt_reg + 1'b1;
                sticky_reg <= sticky_reg | in_ovf;
            end
        end
    end

    assign out_Re  = lane_out[0];
    assign out_Im  = lane_out[1];
    assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed self-checking bench for complex_accumulator (QI=4, QF=4, N_TERMS=4, GUARD=2).
module tb_complex_accumulator;

`ifdef CACC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_Re;
    logic [7:0] in_Im;
    logic       in_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_Re;
    logic [7:0] out_Im;
    logic       out_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    complex_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_Re     (in_Re),
        .in_Im     (in_Im),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Re    (out_Re),
        .out_Im    (out_Im),
        .out_ovf   (out_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted, in_valid left high.
    task automatic send_beat(input logic [7:0] re, input logic [7:0] im, input logic ovf);
        bit done;
        done     = 1'b0;
        in_Re    = re;
        in_Im    = im;
        in_ovf   = ovf;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!done) check_eq("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] re, input logic [7:0] im,
                             input logic [3:0] ovf_mask);
        for (int b = 0; b < 4; b++) begin
            send_beat(re, im, ovf_mask[b]);
        end
        in_valid = 1'b0;
        in_ovf   = 1'b0;
        check_eq({tag, "_latency"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_Re     = '0;
        in_Im     = '0;
        in_ovf    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_Re",    32'(out_Re),    32'h00);
        check_eq("rst_out_Im",    32'(out_Im),    32'h00);
        check_eq("rst_out_ovf",   32'(out_ovf),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4 x (1.0, -0.5)
        run_frame("t1", 8'h10, 8'hF8, 4'b0000);
        check_eq("t1_Re",       32'(out_Re),   32'h40);
        check_eq("t1_Im",       32'(out_Im),   32'hE0);
        check_eq("t1_ovf",      32'(out_ovf),  32'd0);
        check_eq("t1_rdy_low",  32'(in_ready), SKID ? 32'd1 : 32'd0);
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(out_valid), 32'd0);
        check_eq("t1_rdy_back",   32'(in_ready),  32'd1);

        // Re 4 x 3.0 saturates; Im sums to exactly -8.0
        run_frame("t2a", 8'h30, 8'hE0, 4'b0000);
        check_eq("t2a_Re",  32'(out_Re),  32'h7F);
        check_eq("t2a_Im",  32'(out_Im),  32'h80);
        check_eq("t2a_ovf", 32'(out_ovf), 32'd1);
        @(negedge clk);
        // Only Im saturates (4 x -4.0)
        run_frame("t2b", 8'h00, 8'hC0, 4'b0000);
        check_eq("t2b_Re",  32'(out_Re),  32'h00);
        check_eq("t2b_Im",  32'(out_Im),  32'h80);
        check_eq("t2b_ovf", 32'(out_ovf), 32'd1);
        @(negedge clk);

        // Sticky input overflow on beat 2, then cleared for the next frame
        run_frame("t3a", 8'h00, 8'h00, 4'b0010);
        check_eq("t3a_Re",  32'(out_Re),  32'h00);
        check_eq("t3a_ovf", 32'(out_ovf), 32'd1);
        @(negedge clk);
        run_frame("t3b", 8'h00, 8'h00, 4'b0000);
        check_eq("t3b_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);

        // Output stall for 5 cycles
        out_ready = 1'b0;
        run_frame("t4a", 8'h04, 8'h02, 4'b0000);
        check_eq("t4a_Re", 32'(out_Re), 32'h10);
        check_eq("t4a_Im", 32'(out_Im), 32'h08);
        if (!SKID) begin
            in_Re    = 8'h10;
            in_Im    = 8'h10;
            in_valid = 1'b1;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t4_hold_Re",    32'(out_Re),    32'h10);
            check_eq("t4_hold_Im",    32'(out_Im),    32'h08);
            check_eq("t4_hold_rdy",   32'(in_ready),  SKID ? 32'd1 : 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check_eq("t4_release", 32'(out_valid), 32'd0);
        run_frame("t4b", 8'h01, 8'hFF, 4'b0000);
        check_eq("t4b_Re", 32'(out_Re), 32'h04);
        check_eq("t4b_Im", 32'(out_Im), 32'hFC);
        @(negedge clk);

        // Asynchronous reset mid-frame
        send_beat(8'h10, 8'h00, 1'b0);
        send_beat(8'h10, 8'h00, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t5_rst_Re",    32'(out_Re),    32'h00);
        check_eq("t5_rst_Im",    32'(out_Im),    32'h00);
        check_eq("t5_rst_rdy",   32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("t5", 8'h08, 8'h00, 4'b0000);
        check_eq("t5_Re", 32'(out_Re), 32'h20);
        check_eq("t5_Im", 32'(out_Im), 32'h00);
        @(negedge clk);

`ifdef CACC_SKID_EN
        // Two frames streamed against a stalled output
        out_ready = 1'b0;
        run_frame("t6a", 8'h01, 8'h00, 4'b0000);
        check_eq("t6a_Re", 32'(out_Re), 32'h04);
        for (int b = 0; b < 3; b++) begin
            check_eq("t6_rdy_open", 32'(in_ready), 32'd1);
            send_beat(8'h02, 8'h00, 1'b0);
        end
        in_Re    = 8'h02;
        in_valid = 1'b1;
        check_eq("t6_rdy_last", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("t6_rdy_still", 32'(in_ready), 32'd0);
        check_eq("t6_held_Re",   32'(out_Re),   32'h04);
        out_ready = 1'b1;
        #1;
        check_eq("t6_rdy_release", 32'(in_ready),  32'd1);
        check_eq("t6_first_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t6_second_valid", 32'(out_valid), 32'd1);
        check_eq("t6_second_Re",    32'(out_Re),    32'h08);
        @(negedge clk);
        check_eq("t6_drained", 32'(out_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/complex_accumulator.md
Name: complex_accumulator

Overview:
- Downstream stage of mult_fixed_complex in the convolution datapath.
- Consumes one complex fixed-point product (y_Re, y_Im, overflow) per accepted beat and accumulates N_TERMS products into a wide internal accumulator.
- When the frame is complete, it presents one saturated complex sum in the same QI.QF format, using a valid/ready handshake.
- Forms the accumulate half of a complex MAC (one output sample of a convolution/correlation).

Parameters:
- QI, 4, integer bits including sign (matches multiplier).
- QF, 4, fractional bits.
- N_TERMS, 4, products per output frame; must be >= 2.
- GUARD, 2, extra accumulator MSBs; must satisfy GUARD >= clog2(N_TERMS). Elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_Re  in  QI+QF  signed product real part.
- in_Im  in  QI+QF  signed product imaginary part.
- in_ovf  in  1  multiplier overflow flag for this beat.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_Re  out  QI+QF  saturated real sum.
- out_Im  out  QI+QF  saturated imaginary sum.
- out_ovf  out  1  frame overflow (sticky input ovf OR output saturation).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n). Reset values: all outputs 0 except in_ready=1; accumulators, term counter and sticky flag are 0; state is ACC.
- Widths and arithmetic:
  - WIDTH = QI+QF; ACCW = WIDTH+GUARD.
  - Inputs are sign-extended to ACCW, then added in two's complement. There is no wrap internally, given the GUARD constraint.
- Beat acceptance: a beat is accepted on a rising edge with in_valid && in_ready.
- State ACC:
  - in_ready=1, out_valid=0.
  - Each accepted beat: acc += input, sticky |= in_ovf, cnt++.
  - On the beat with cnt==N_TERMS-1, register the results and go to OUT:
    - out_Re/out_Im = sat(acc+input).
    - out_ovf = sticky|in_ovf|saturated_Re|saturated_Im.
    - Clear acc, cnt and sticky in the same edge.
  - Result latency: out_valid rises one cycle after the last beat is accepted.
- State OUT:
  - in_ready=0, out_valid=1; outputs held stable while out_ready=0.
  - On out_valid && out_ready, go to ACC; out_valid=0 next cycle. out_Re/out_Im/out_ovf keep their last value (they are don't-care when not valid).
- Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (0x80..0x7F for 8 bits). An exact minimum (e.g. -8.0) is not saturation.
- in_valid low in ACC: no change, cnt holds (gaps between beats allowed).
- Reset mid-frame: partial sum discarded; the next accepted beat is term 0.
- in_ovf does not alter arithmetic; it only sets the flag.

Optional Feature:
- Macro: CACC_SKID_EN.
- Defined: no OUT stall. Accumulation continues in ACC while the result is held in the output register.
  - in_ready = !(cnt==N_TERMS-1 && out_valid && !out_ready).
  - A completing beat arriving in the same cycle as an out handshake is accepted, and the new result loads the next edge.
- Undefined: behaviour exactly as specified above (in_ready=0 during OUT).

Decomposition:
- Package cplx_fixed_pkg holds:
  - WIDTH/ACCW localparam helpers.
  - State enum {ACC, OUT}.
  - A sat_to_width function (returns value plus saturated bit).
- Shared with mult_fixed_complex for the format constants.
- One natural sub-module: fixed_saturate (ACCW in -> WIDTH out + flag), instantiated for Re and Im.

Test Plan (defaults QI=4, QF=4, N_TERMS=4, GUARD=2):
1. Four back-to-back beats in_Re=0x10 (1.0), in_Im=0xF8 (-0.5), ovf=0, out_ready=1 -> out_valid one cycle after 4th beat; out_Re=0x40, out_Im=0xE0, out_ovf=0; in_ready low exactly one cycle.
2. Four beats Re=0x30 (3.0), Im=0xE0 (-2.0) -> out_Re=0x7F (sat), out_Im=0x80 (exact -8.0), out_ovf=1; repeat with Im=0xC0 each -> out_Im=0x80, out_ovf=1.
3. Four beats of zero with in_ovf=1 on beat 2 only -> out_Re=0x00, out_Im=0x00, out_ovf=1; following frame with no ovf -> out_ovf=0 (sticky cleared).
4. out_ready=0 for 5 cycles after result -> out_valid/out_Re/out_Im stable, in_ready=0, offered in_valid beats not consumed; release -> next frame sums correctly.
5. Two beats of 0x10 accepted, assert rst_n=0 asynchronously between edges -> outputs 0 immediately; then four beats of 0x08 -> out_Re=0x20.
6. (CACC_SKID_EN) out_ready held 0, two frames streamed -> first result held, in_ready drops only at the 4th beat of frame 2; release -> both results delivered in order, no beat lost.
